// File: rtl/wbs_qp_packer.sv
// wbs_qp_packer: packs two Wishbone writes into one query-patch SRAM word; QP_PACKER_RDBACK_EN adds SRAM readback
module wbs_qp_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
  parameter int          ADDR_W    = 9,
  parameter int          PATCH_W   = 55
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic               wbs_mode,
  output logic               qp_csb0,
  output logic               qp_web0,
  output logic [ADDR_W-1:0]  qp_addr0,
  output logic [PATCH_W-1:0] qp_wpatch0,
  input  logic [PATCH_W-1:0] qp_rpatch0
);
  localparam int HI_W = PATCH_W - 32;
  typedef enum logic [2:0] {
    IDLE,
    WR,
`ifdef QP_PACKER_RDBACK_EN
    RD0,
    RD1,
`endif
    ACK
  } state_t;
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d, addr_q, addr_d, ptr_inc;
  logic [31:0]        hold_lo_q, hold_lo_d, dat_q, dat_d;
  logic [15:0]        wr_cnt_q, wr_cnt_d;
  logic [PATCH_W-1:0] wpatch_q, wpatch_d;
  logic               autoinc_q, autoinc_d, wrap_q, wrap_d, merr_q, merr_d;
  logic               csb_q, csb_d, web_q, web_d;
  logic               req, wr_ok, wrap_inc, unused_ok;
  logic [2:0]         off;
`ifdef QP_PACKER_RDBACK_EN
  logic [HI_W-1:0]    hold_hi_q, hold_hi_d;
`endif
  assign off       = wbs_adr_i[4:2];
  assign req       = state_q == IDLE && wbs_stb_i && wbs_cyc_i && wbs_adr_i[31:5] == BASE_ADDR[31:5];
  assign wr_ok     = wbs_we_i && wbs_sel_i == 4'hF;
  assign ptr_inc   = ptr_q + ADDR_W'(autoinc_q);
  assign wrap_inc  = autoinc_q && &ptr_q;
  assign wbs_ack_o = state_q == ACK;
  assign wbs_dat_o = wbs_ack_o ? dat_q : 32'h0;
  assign qp_csb0   = csb_q;
  assign qp_web0   = web_q;
  assign qp_addr0  = addr_q;
  assign qp_wpatch0 = wpatch_q;
  assign unused_ok = ^{wbs_adr_i[1:0], qp_rpatch0};
  // Request decode, register updates and the SRAM strobe for the next cycle
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_lo_d = hold_lo_q;
    dat_d     = dat_q;
    wr_cnt_d  = wr_cnt_q;
    autoinc_d = autoinc_q;
    wrap_d    = wrap_q;
    merr_d    = merr_q;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    addr_d    = ptr_q;
    wpatch_d  = '0;
`ifdef QP_PACKER_RDBACK_EN
    hold_hi_d = hold_hi_q;
`endif
    case (state_q)
      IDLE: if (req) begin
        state_d = ACK;
        dat_d   = 32'h0;
        if (wr_ok) begin
          case (off)
            3'd0: begin
              autoinc_d = wbs_dat_i[0];
              if (wbs_dat_i[1]) begin
                ptr_d    = '0;
                wrap_d   = 1'b0;
                merr_d   = 1'b0;
                wr_cnt_d = '0;
              end
            end
            3'd1: ptr_d = wbs_dat_i[ADDR_W-1:0];
            3'd2: hold_lo_d = wbs_dat_i;
            3'd3: if (wbs_mode) begin
              state_d  = WR;
              csb_d    = 1'b0;
              web_d    = 1'b0;
              wpatch_d = {wbs_dat_i[HI_W-1:0], hold_lo_q};
              ptr_d    = ptr_inc;
              wrap_d   = wrap_q | wrap_inc;
              wr_cnt_d = wr_cnt_q + 16'(~&wr_cnt_q);
            end else merr_d = 1'b1;
            default: ;
          endcase
        end else if (!wbs_we_i) begin
          case (off)
            3'd0: dat_d = {31'h0, autoinc_q};
            3'd1: dat_d = 32'(ptr_q);
`ifdef QP_PACKER_RDBACK_EN
            3'd2: if (wbs_mode) begin
              state_d = RD0;
              csb_d   = 1'b0;
            end else merr_d = 1'b1;
            3'd3: begin
              dat_d  = 32'(hold_hi_q);
              ptr_d  = ptr_inc;
              wrap_d = wrap_q | wrap_inc;
            end
`endif
            3'd4: dat_d = {wr_cnt_q, 13'h0, merr_q, wrap_q, state_q != IDLE};
            default: ;
          endcase
        end
      end
`ifdef QP_PACKER_RDBACK_EN
      RD0: state_d = RD1;
      RD1: begin
        state_d   = ACK;
        dat_d     = qp_rpatch0[31:0];
        hold_hi_d = qp_rpatch0[PATCH_W-1:32];
      end
`endif
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset also abandons any SRAM cycle in flight
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_lo_q <= '0;
      dat_q     <= '0;
      wr_cnt_q  <= '0;
      autoinc_q <= 1'b0;
      wrap_q    <= 1'b0;
      merr_q    <= 1'b0;
      csb_q     <= 1'b1;
      web_q     <= 1'b1;
      addr_q    <= '0;
      wpatch_q  <= '0;
`ifdef QP_PACKER_RDBACK_EN
      hold_hi_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_lo_q <= hold_lo_d;
      dat_q     <= dat_d;
      wr_cnt_q  <= wr_cnt_d;
      autoinc_q <= autoinc_d;
      wrap_q    <= wrap_d;
      merr_q    <= merr_d;
      csb_q     <= csb_d;
      web_q     <= web_d;
      addr_q    <= addr_d;
      wpatch_q  <= wpatch_d;
`ifdef QP_PACKER_RDBACK_EN
      hold_hi_q <= hold_hi_d;
`endif
    end
  end
endmodule

// File: tb/tb_wbs_qp_packer.sv
// tb_wbs_qp_packer: randomized transaction-level checking of wbs_qp_packer against a register-map model
module tb_wbs_qp_packer;
  localparam logic [31:0] BASE = 32'h3000_0100;
  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 1'b0, wcyc = 1'b0, we = 1'b0, mode = 1'b1;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat = '0, adr = '0;
  logic        ack, csb, web;
  logic [31:0] dato;
  logic [8:0]  addr;
  logic [54:0] wpatch, rpatch;
  logic [54:0] sram [512];
  int          total = 0, bad = 0, cyc_n = 0;
  bit          chk_on = 0;
  int          exp_e = -10, exp_ack = -10;
  bit          exp_acc = 0, exp_wr = 0;
  logic [8:0]  exp_addr;
  logic [54:0] exp_wp, last_wp;
  logic [31:0] exp_rd, rd;
  int          m_ptr;
  bit          m_ai, m_wrap, m_merr;
  logic [31:0] m_lo;
  logic [22:0] m_hi;
  logic [15:0] m_cnt;
  logic [54:0] m_mem [512];

  wbs_qp_packer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(wcyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dato),
    .wbs_mode(mode), .qp_csb0(csb), .qp_web0(web), .qp_addr0(addr), .qp_wpatch0(wpatch),
    .qp_rpatch0(rpatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  // SRAM environment: one-cycle read latency, cleared by reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) sram[i] <= '0;
      rpatch <= '0;
    end else if (!csb) begin
      if (!web) sram[addr] <= wpatch;
      else rpatch <= sram[addr];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc_n, act, expv);
    end
  endtask

  // Per-cycle comparison of the bus and SRAM outputs against the expected transaction schedule
  always @(negedge clk) if (chk_on) begin
    check("ack", ack, cyc_n == exp_ack);
    check("csb", csb, !(exp_acc && cyc_n == exp_e));
    check("web", web, !(exp_acc && exp_wr && cyc_n == exp_e));
    if (!csb) check("addr", addr, exp_addr);
    if (!csb && !web) begin
      check("wpatch", wpatch, exp_wp);
      last_wp = wpatch;
    end
    if (csb) check("wpatch_idle", wpatch, 0);
    check("dat_o", dato, ack ? exp_rd : 32'h0);
  end

  task automatic model_reset();
    m_ptr = 0; m_ai = 0; m_wrap = 0; m_merr = 0; m_lo = '0; m_hi = '0; m_cnt = '0;
    for (int i = 0; i < 512; i++) m_mem[i] = '0;
  endtask

  task automatic bump();
    if (m_ai) begin
      if (m_ptr == 511) m_wrap = 1;
      m_ptr = (m_ptr + 1) % 512;
    end
  endtask

  // Transaction-level register-map model: latency, SRAM access and read data for one request
  task automatic model(input bit w, input int off, input logic [31:0] d, input logic [3:0] s, output int lat);
    lat = 1; exp_acc = 0; exp_wr = 0; exp_rd = '0; exp_addr = 9'(m_ptr); exp_wp = '0;
    if (w) begin
      if (s == 4'hF) begin
        if (off == 0) begin
          m_ai = d[0];
          if (d[1]) begin m_ptr = 0; m_wrap = 0; m_merr = 0; m_cnt = '0; end
        end else if (off == 1) m_ptr = int'(d[8:0]);
        else if (off == 2) m_lo = d;
        else if (off == 3) begin
          if (mode) begin
            lat = 2; exp_acc = 1; exp_wr = 1;
            exp_wp = {d[22:0], m_lo};
            m_mem[m_ptr] = exp_wp;
            if (m_cnt != 16'hFFFF) m_cnt++;
            bump();
          end else m_merr = 1;
        end
      end
    end else begin
      if (off == 0) exp_rd = {31'h0, m_ai};
      else if (off == 1) exp_rd = 32'(m_ptr);
`ifdef QP_PACKER_RDBACK_EN
      else if (off == 2) begin
        if (mode) begin
          lat = 3; exp_acc = 1;
          exp_rd = m_mem[m_ptr][31:0];
          m_hi = m_mem[m_ptr][54:32];
        end else m_merr = 1;
      end else if (off == 3) begin
        exp_rd = {9'h0, m_hi};
        bump();
      end
`endif
      else if (off == 4) exp_rd = {m_cnt, 13'h0, m_merr, m_wrap, 1'b0};
    end
  endtask

  task automatic drive(input bit w, input int off, input logic [31:0] d, input logic [3:0] s);
    int lat;
    @(negedge clk); #1;
    model(w, off, d, s, lat);
    exp_e = cyc_n + 1;
    exp_ack = cyc_n + lat;
    stb = 1; wcyc = 1; we = w; adr = BASE + 32'(off * 4); dat = d; sel = s;
  endtask

  task automatic bus(input bit w, input int off, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    bit ok = 0;
    drive(w, off, d, s);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) begin ok = 1; break; end
    end
    r = dato;
    stb = 0; wcyc = 0; we = 0;
    if (!ok) check("ack_timeout", 0, 1);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    logic [31:0] r;
    bus(1, off, d, 4'hF, r);
  endtask

  task automatic rd_lit(input string nm, input int off, input logic [31:0] lit);
    logic [31:0] r;
    bus(0, off, 32'h0, 4'hF, r);
    check(nm, r, lit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int off;
    logic [31:0] d;
    model_reset();
    @(posedge clk); #1 chk_on = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 0;
    check("rst_ptr_addr", addr, 0);
    // T1: packed write at pointer 0
    wr(0, 32'h1); wr(1, 32'h0); wr(2, 32'hDEAD_BEEF); wr(3, 32'h0001_2345);
    check("t1_wpatch", last_wp, 55'h12345_DEADBEEF);
    rd_lit("t1_ptr", 1, 32'h1);
    rd_lit("t1_status", 4, 32'h0001_0000);
`ifdef QP_PACKER_RDBACK_EN
    // T3: readback of the T1 patch
    wr(1, 32'h0);
    rd_lit("t3_lo", 2, 32'hDEAD_BEEF);
    rd_lit("t3_hi", 3, 32'h0001_2345);
    rd_lit("t3_ptr", 1, 32'h1);
`endif
    // T2: write at the top address wraps the pointer
    wr(1, 32'd511); wr(2, 32'hA5A5_A5A5); wr(3, 32'h007F_FFFF);
    rd_lit("t2_ptr", 1, 32'h0);
    rd_lit("t2_status", 4, 32'h0002_0002);
    wr(0, 32'h2);
    rd_lit("t2_clr_status", 4, 32'h0);
    rd_lit("t2_clr_ctrl", 0, 32'h0);
    wr(0, 32'h1);
    // T4: memory not owned by the bus
    mode = 0;
    wr(3, 32'h0000_0777);
    rd_lit("t4_status", 4, 32'h0000_0004);
    rd_lit("t4_ptr", 1, 32'h0);
    mode = 1;
    // T5: partial byte select and unmapped offset
    bus(1, 1, 32'h55, 4'h3, rd);
    rd_lit("t5_ptr", 1, 32'h0);
    rd_lit("t5_unmapped", 7, 32'h0);
    // Random traffic
    for (int n = 0; n < 300; n++) begin
      off = $urandom_range(0, 5);
      if (off == 5) off = 7;
      d = $urandom;
      if (off == 0) d = {30'h0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0};
      if (off == 1 && $urandom_range(0, 1) == 1) d = 32'($urandom_range(505, 511));
      mode = $urandom_range(0, 9) != 0;
      bus($urandom_range(0, 1) == 1, off, d, ($urandom_range(0, 7) == 0) ? 4'h3 : 4'hF, rd);
    end
    mode = 1;
    // T6: reset while the SRAM write strobe is active
    wr(1, 32'd7);
    drive(1, 3, 32'h1, 4'hF);
    @(negedge clk); #1;
    rst = 1; stb = 0; wcyc = 0; we = 0; exp_acc = 0; exp_ack = -10;
    @(negedge clk);
    check("t6_csb", csb, 1);
    check("t6_web", web, 1);
    check("t6_ack", ack, 0);
    #1 rst = 0;
    model_reset();
    rd_lit("t6_ptr", 1, 32'h0);
    rd_lit("t6_status", 4, 32'h0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
